// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter generator.
package pc_pkg;

    localparam int PC_WIDTH      = 64;
    localparam int PC_INC        = 4;
    localparam int PC_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

endpackage

// File: rtl/D_FF.sv
// Single-bit D flip-flop with synchronous reset-to-value and load enable.
module D_FF (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_reg.sv
// WIDTH-bit register assembled from D_FF cells, one per bit.
module pc_reg #(
    parameter int               WIDTH       = pc_pkg::PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        D_FF u_ff (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VALUE[i]),
            .en      (en),
            .d       (d[i]),
            .q       (q[i])
        );
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALTED control with stall, halt and redirect.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = PC_INC,
    parameter int               ALIGN_BITS   = PC_ALIGN_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             misalign_err
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_d;
    logic             pc_en;
    logic             valid_d;
    logic             err_d;
    logic             aligned;

    assign aligned = (redirect_target[ALIGN_BITS-1:0] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_valid     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_valid     <= valid_d;
            misalign_err <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        pc_en   = 1'b0;
        valid_d = pc_valid;
        err_d   = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
            end
            RUN: begin
                // redirect outranks halt and stall
                if (redirect_valid) begin
                    if (aligned) begin
                        pc_d    = redirect_target;
                        pc_en   = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = HALTED;
                    end
                end else if (halt) begin
                    valid_d = 1'b0;
                    state_d = HALTED;
                end else if (!stall) begin
                    pc_d    = pc + INC_W;
                    pc_en   = 1'b1;
                    valid_d = 1'b1;
                end
            end
            HALTED: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    if (aligned) begin
                        pc_d    = redirect_target;
                        pc_en   = 1'b1;
                        valid_d = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    pc_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc)
    );

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 64: program-counter width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 Parameter INC, default 4: sequential increment per advancing cycle.
REQ-004 Parameter ALIGN_BITS, default 2: low bits of a redirect target that must be zero.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  hold the PC for this cycle.
REQ-008 halt  input  1  stop fetching; enter HALTED.
REQ-009 redirect_valid  input  1  load redirect_target this cycle.
REQ-010 redirect_target  input  WIDTH  branch or exception target address.
REQ-011 pc  output  WIDTH  registered fetch address.
REQ-012 pc_valid  output  1  registered; pc is a live fetch address.
REQ-013 misalign_err  output  1  registered one-cycle pulse on a misaligned redirect.

Function
REQ-014 The FSM SHALL have the states BOOT, RUN and HALTED.
REQ-015 In BOOT, the block SHALL hold pc and drive pc_valid=0, then move to RUN on the next edge with pc unchanged and pc_valid=1.
REQ-016 In RUN, each edge SHALL apply the first matching case in this priority order: redirect_valid, halt, stall, increment.
REQ-017 A RUN redirect with target[ALIGN_BITS-1:0]==0 SHALL load pc<=redirect_target and keep pc_valid=1.
REQ-018 A RUN redirect with nonzero low ALIGN_BITS SHALL hold pc, set misalign_err=1 for exactly one cycle, and go to HALTED.
REQ-019 Halt in RUN SHALL hold pc, clear pc_valid from the next cycle, and go to HALTED.
REQ-020 Stall in RUN SHALL hold pc and pc_valid unchanged.
REQ-021 Otherwise RUN SHALL apply pc<=pc+INC, truncated to WIDTH bits, so that all-ones minus INC-1 wraps to 0 with no error.
REQ-022 HALTED SHALL hold pc with pc_valid=0, ignoring stall and halt.
REQ-023 Only an aligned redirect SHALL leave HALTED: it goes to RUN with pc<=target and pc_valid=1 on the same edge.
REQ-024 A misaligned redirect in HALTED SHALL pulse misalign_err and stay in HALTED.
REQ-025 misalign_err SHALL be 0 on every cycle not named in REQ-018 or REQ-024.
REQ-026 Redirect, halt and stall asserted in BOOT SHALL be ignored.
REQ-027 Redirect and halt asserted together SHALL resolve to the redirect.

Reset
REQ-028 While reset=1 at an edge, the block SHALL set pc=RESET_VECTOR, pc_valid=0, misalign_err=0 and state=BOOT, overriding all other inputs.
REQ-029 Reset asserted mid-operation, in any state, SHALL take effect at the next edge with no partial update.
REQ-030 The first valid fetch address after reset deassertion SHALL be RESET_VECTOR, one cycle after deassertion.

Structure
REQ-031 A shared package pc_pkg SHALL hold the pc_state_t enum (BOOT, RUN, HALTED) and the default constants for WIDTH, INC and ALIGN_BITS.
REQ-032 Sub-module pc_reg SHALL be a WIDTH-bit register with synchronous reset-to-value and load enable, built per bit from the existing D_FF cell inside a generate loop.
REQ-033 The next-state and next-PC logic SHALL sit in pc_gen; pc_gen SHALL instantiate pc_reg once, for the pc.

Verification
REQ-034 Reset, then release with no other inputs (defaults) -> cycle 1: pc=0, pc_valid=0; cycle 2: pc=0, pc_valid=1; cycle 3: pc=4; cycle 4: pc=8.
REQ-035 Stall for 3 cycles at pc=0x10 -> pc stays 0x10 for 3 cycles, then advances to 0x14.
REQ-036 Redirect to 0x1000 with stall=1 and halt=1 at the same time -> pc=0x1000, state RUN, next pc=0x1004.
REQ-037 Redirect to 0x1002 -> misalign_err=1 for one cycle, pc held, pc_valid=0; then redirect to 0x2000 -> pc=0x2000, pc_valid=1.
REQ-038 With pc=0xFFFF_FFFF_FFFF_FFFC -> next pc=0 with pc_valid=1; with halt then reset mid-HALTED -> pc=RESET_VECTOR and state BOOT.
REQ-039 With WIDTH=32, INC=2, ALIGN_BITS=1 -> pc steps by 2, a redirect to 0x3 is flagged misaligned, and a redirect to 0x6 is accepted.
